aes128_round_sequencer: RTL and testbench



---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/aes_round_core.sv | 45 ++++
 rtl/key_generation.sv | 32 +++
 rtl/aes128_round_sequencer.sv | 133 +++++++++++++
 tb/tb_aes128_round_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, sequencer state enum, S-box, Rcon and GF(2^8) doubling.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned RND_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b sits at bits [2047-8b -: 8]; 2047-8b == {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b111} -: 8];
  endfunction

  // Round constant for key_generation round indices 1..10; zero elsewhere.
  function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_core.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (bypassed on
// the last round), AddRoundKey.
// Ports: state_in, round_key, is_final (skip MixColumns), state_out.
module aes_round_core
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state_in,
  input  logic [BLK_W-1:0] round_key,
  input  logic             is_final,
  output logic [BLK_W-1:0] state_out
);

  // Byte i of the block is column i/4, row i%4.
  logic [7:0] sub_b [16];
  logic [7:0] shf_b [16];
  logic [7:0] mix_b [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sub_b[i] = sbox(state_in[BLK_W-1-8*i -: 8]);
  end

  // Row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_shf_col
    for (genvar r = 0; r < 4; r++) begin : g_shf_row
      assign shf_b[4*c+r] = sub_b[4*((c+r)%4)+r];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mix_b[4*c+0] = xtime(shf_b[4*c+0]) ^ xtime(shf_b[4*c+1]) ^ shf_b[4*c+1]
                        ^ shf_b[4*c+2] ^ shf_b[4*c+3];
    assign mix_b[4*c+1] = shf_b[4*c+0] ^ xtime(shf_b[4*c+1]) ^ xtime(shf_b[4*c+2])
                        ^ shf_b[4*c+2] ^ shf_b[4*c+3];
    assign mix_b[4*c+2] = shf_b[4*c+0] ^ shf_b[4*c+1] ^ xtime(shf_b[4*c+2])
                        ^ xtime(shf_b[4*c+3]) ^ shf_b[4*c+3];
    assign mix_b[4*c+3] = xtime(shf_b[4*c+0]) ^ shf_b[4*c+0] ^ shf_b[4*c+1]
                        ^ shf_b[4*c+2] ^ xtime(shf_b[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign state_out[BLK_W-1-8*i -: 8] = (is_final ? shf_b[i] : mix_b[i])
                                       ^ round_key[BLK_W-1-8*i -: 8];
  end

endmodule

// File: rtl/key_generation.sv
// AES-128 key schedule step: derives round key r from round key r-1.
// Ports: key_in (previous round key), round_num (1..10), key_out (next round key).
module key_generation
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] key_in,
  input  logic [RND_W-1:0] round_num,
  output logic [BLK_W-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, tmp_w;
  logic [31:0] k0, k1, k2, k3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  // RotWord, SubWord, then Rcon on the leading byte.
  assign rot_w = {w3[23:0], w3[31:24]};
  assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
  assign tmp_w = sub_w ^ {rcon(round_num), 24'h000000};

  assign k0 = w0 ^ tmp_w;
  assign k1 = w1 ^ k0;
  assign k2 = w2 ^ k1;
  assign k3 = w3 ^ k2;

  assign key_out = {k0, k1, k2, k3};

endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one shared round datapath and key schedule step reused
// for ten cycles per block, valid/ready handshakes on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_text/in_key accept a block
// in IDLE; out_valid/out_ready/out_text present the ciphertext in DONE; busy and
// round_idx expose progress. ZERO_OUT=1 forces out_text to zero while out_valid=0.
module aes128_round_sequencer
  import aes_pkg::*;
#(
  parameter bit ZERO_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_text,
  input  logic [BLK_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_text,
  output logic             busy,
  output logic [RND_W-1:0] round_idx
);

  aes_fsm_e         fsm_q, fsm_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] rkey_q, rkey_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [BLK_W-1:0] out_text_q, out_text_d;

  logic [BLK_W-1:0] next_key;
  logic [BLK_W-1:0] round_out;
  logic             last_rnd;

  assign last_rnd = (rnd_q == RND_W'(AES_NR));

  key_generation u_keygen (
    .key_in    (rkey_q),
    .round_num (rnd_q),
    .key_out   (next_key)
  );

  aes_round_core u_core (
    .state_in  (blk_q),
    .round_key (next_key),
    .is_final  (last_rnd),
    .state_out (round_out)
  );

  // Next-state and registered-output logic.
  always_comb begin
    fsm_d  = fsm_q;
    blk_d  = blk_q;
    rkey_d = rkey_q;
    rnd_d  = rnd_q;

    if (rnd_q > RND_W'(AES_NR)) begin
      // Out-of-range round counter: abandon and recover.
      fsm_d = IDLE;
      rnd_d = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            blk_d  = in_text ^ in_key;
            rkey_d = in_key;
            rnd_d  = RND_W'(1);
            fsm_d  = ROUND;
          end
        end
        ROUND: begin
          if (rnd_q == '0) begin
            fsm_d = IDLE;
          end else begin
            blk_d  = round_out;
            rkey_d = next_key;
            if (last_rnd) begin
              fsm_d = DONE;
            end else begin
              rnd_d = rnd_q + RND_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_d = IDLE;
            rnd_d = '0;
          end
        end
        default: begin
          fsm_d = IDLE;
          rnd_d = '0;
        end
      endcase
    end

    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
    out_text_d  = (out_valid_d || !ZERO_OUT) ? blk_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      blk_q       <= '0;
      rkey_q      <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_text_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      blk_q       <= blk_d;
      rkey_q      <= rkey_d;
      rnd_q       <= rnd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_text_q  <= out_text_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_text  = out_text_q;
  assign round_idx = rnd_q;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Self-checking bench for aes128_round_sequencer against a byte-array AES model.
module tb_aes128_round_sequencer;

  localparam logic [127:0] PT1  = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] KEY1 = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] CT1  = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] R1_1 = 128'h5847088b15b61cba59d4e2e8cd39dfce;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [127:0] in_text, in_key;
  logic         in_ready_a, out_valid_a, busy_a;
  logic [3:0]   round_idx_a;
  logic [127:0] out_text_a;
  logic         in_ready_b, out_valid_b, busy_b;
  logic [3:0]   round_idx_b;
  logic [127:0] out_text_b;

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sb [256];
  logic [127:0] obs_r1, obs_ct;

  always #5 clk = ~clk;

  aes128_round_sequencer #(.ZERO_OUT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_text(in_text), .in_key(in_key), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_text(out_text_a), .busy(busy_a), .round_idx(round_idx_a)
  );

  // Second instance exposes the internal round state on out_text.
  aes128_round_sequencer #(.ZERO_OUT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_text(in_text), .in_key(in_key), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_text(out_text_b), .busy(busy_b), .round_idx(round_idx_b)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      sb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Cipher state after nr rounds (0..10).
  function automatic logic [127:0] model(input logic [127:0] pt, input logic [127:0] key,
                                         input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] k [16];
    logic [7:0] a [4];
    logic [7:0] rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8];
      k[i] = key[127-8*i -: 8];
      s[i] = s[i] ^ k[i];
    end
    for (int r = 1; r <= nr; r++) begin
      t[0] = sb[k[13]] ^ rc; t[1] = sb[k[14]]; t[2] = sb[k[15]]; t[3] = sb[k[12]];
      for (int j = 0; j < 4; j++) k[j] = k[j] ^ t[j];
      for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int i = 0; i < 4; i++) a[i] = s[4*c+i];
          for (int i = 0; i < 4; i++)
            s[4*c+i] = gmul(a[i], 8'h02) ^ gmul(a[(i+1)%4], 8'h03) ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready_a); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_a); end
    checks++; if (round_idx_a !== 4'd0) begin errors++; $display("FAIL rst_round_idx got %0d exp 0", round_idx_a); end
    checks++; if (out_text_a !== 128'h0) begin errors++; $display("FAIL rst_out_text got %h exp 0", out_text_a); end
    checks++; if (out_text_b !== 128'h0) begin errors++; $display("FAIL rst_state got %h exp 0", out_text_b); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready_a); end
  endtask

  // One full transaction from accept to output handshake, entered at a negedge in IDLE.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input int stall);
    logic [127:0] ct, exp_k;
    logic [3:0]   exp_ri;
    int           w;
    ct = model(pt, key, 10);
    w = 0;
    while (in_ready_a !== 1'b1 && w < 30) begin @(negedge clk); w++; end
    checks++;
    if (in_ready_a !== 1'b1) begin
      errors++; $display("FAIL idle_wait got in_ready %b exp 1", in_ready_a); return;
    end
    in_text = pt; in_key = key; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_text = {$urandom, $urandom, $urandom, $urandom};
    in_key  = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_k  = model(pt, key, k);
      exp_ri = 4'((k < 10) ? k + 1 : 10);
      checks++; if (out_valid_a !== (k == 10)) begin errors++; $display("FAIL lat_out_valid k=%0d got %b", k, out_valid_a); end
      checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL busy_in_ready k=%0d got %b exp 0", k, in_ready_a); end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL busy k=%0d got %b exp 1", k, busy_a); end
      checks++; if (round_idx_a !== exp_ri) begin errors++; $display("FAIL round_idx k=%0d got %0d exp %0d", k, round_idx_a, exp_ri); end
      checks++; if (out_text_a !== ((k == 10) ? ct : 128'h0)) begin errors++; $display("FAIL zero_out k=%0d got %h", k, out_text_a); end
      checks++; if (out_text_b !== exp_k) begin errors++; $display("FAIL round_state k=%0d got %h exp %h", k, out_text_b, exp_k); end
      if (k == 1) obs_r1 = out_text_b;
      if (k < 10) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        in_text   = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid  = 1'b0;
        out_ready = (stall == 0);
      end
    end
    obs_ct = out_text_a;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL stall_valid s=%0d got %b exp 1", s, out_valid_a); end
      checks++; if (out_text_a !== ct) begin errors++; $display("FAIL stall_text s=%0d got %h exp %h", s, out_text_a, ct); end
      checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL stall_in_ready s=%0d got %b exp 0", s, in_ready_a); end
      in_valid  = (s == stall - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      out_ready = (s == stall - 1);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL hs_out_valid got %b exp 0", out_valid_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL hs_in_ready got %b exp 1", in_ready_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL hs_busy got %b exp 0", busy_a); end
    checks++; if (round_idx_a !== 4'd0) begin errors++; $display("FAIL hs_round_idx got %0d exp 0", round_idx_a); end
    checks++; if (out_text_a !== 128'h0) begin errors++; $display("FAIL hs_out_text got %h exp 0", out_text_a); end
  endtask

  task automatic test_known_vectors();
    run_block(PT1, KEY1, 0);
    checks++; if (obs_ct !== CT1) begin errors++; $display("FAIL kv1_ct got %h exp %h", obs_ct, CT1); end
    checks++; if (obs_r1 !== R1_1) begin errors++; $display("FAIL kv1_round1 got %h exp %h", obs_r1, R1_1); end
    run_block(PT2, KEY2, 0);
    checks++; if (obs_ct !== CT2) begin errors++; $display("FAIL kv2_ct got %h exp %h", obs_ct, CT2); end
  endtask

  task automatic test_stall();
    run_block(PT1, KEY1, 20);
    checks++; if (obs_ct !== CT1) begin errors++; $display("FAIL stall_ct got %h exp %h", obs_ct, CT1); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_q [$];
    int cyc, last_acc, n_acc, n_out;
    bit sel;
    cyc = 0; last_acc = -1; n_acc = 0; n_out = 0; sel = 1'b0;
    in_text = PT1; in_key = KEY1; in_valid = 1'b1; out_ready = 1'b1;
    while (n_out < 4 && cyc < 100) begin
      if (out_valid_a === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got %h exp none", out_text_a);
        end else begin
          if (out_text_a !== exp_q[0]) begin errors++; $display("FAIL b2b_ct got %h exp %h", out_text_a, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        n_out++;
      end else begin
        checks++; if (out_text_a !== 128'h0) begin errors++; $display("FAIL b2b_zero_out got %h exp 0", out_text_a); end
      end
      if (in_ready_a === 1'b1 && in_valid) begin
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc != 12) begin errors++; $display("FAIL b2b_spacing got %0d exp 12", cyc - last_acc); end
        end
        last_acc = cyc;
        exp_q.push_back(sel ? CT2 : CT1);
        n_acc++;
        sel = ~sel;
        @(posedge clk); #1;
        if (n_acc == 4) in_valid = 1'b0;
        else begin in_text = sel ? PT2 : PT1; in_key = sel ? KEY2 : KEY1; end
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (n_out != 4) begin errors++; $display("FAIL b2b_timeout got %0d outputs exp 4", n_out); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    in_text = PT2; in_key = KEY2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (round_idx_a !== 4'd5) begin errors++; $display("FAIL mid_round_idx got %0d exp 5", round_idx_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 1", in_ready_a); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b exp 0", out_valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy_a); end
    checks++; if (round_idx_a !== 4'd0) begin errors++; $display("FAIL mid_rst_round_idx got %0d exp 0", round_idx_a); end
    checks++; if (out_text_a !== 128'h0) begin errors++; $display("FAIL mid_rst_out_text got %h exp 0", out_text_a); end
    checks++; if (out_text_b !== 128'h0) begin errors++; $display("FAIL mid_rst_state got %h exp 0", out_text_b); end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid_a !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abandoned_pulse got 1 exp 0"); end
    run_block(PT1, KEY1, 1);
    checks++; if (obs_ct !== CT1) begin errors++; $display("FAIL post_rst_ct got %h exp %h", obs_ct, CT1); end
  endtask

  task automatic test_random();
    logic [127:0] pt, key;
    for (int n = 0; n < 5; n++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      run_block(pt, key, $urandom_range(0, 3));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_text = '0; in_key = '0;
    build_sbox();
    test_reset();
    test_known_vectors();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
